// File: rtl/des_f_function.sv
// DES round function f(R,K): expansion, subkey mix, S-boxes S1..S8 and permutation P.
// One-cycle latency with a registered result and valid flag.
module des_f_function (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] r_in,
    input  logic [47:0] subkey,
    output logic        out_valid,
    output logic [31:0] f_out
);

    localparam int unsigned R_W  = 32;
    localparam int unsigned X_W  = 48;
    localparam int unsigned N_SB = 8;

    // Each table holds 64 nibbles; entry row*16+col sits at the left, read MSB first.
    localparam logic [255:0] SBOX [N_SB] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_lookup(input logic [255:0] tab, input logic [5:0] b);
        logic [5:0] idx;
        logic [7:0] pos;
        idx = {b[5], b[0], b[4:1]};
        pos = 8'd252 - {idx, 2'b00};
        return tab[pos +: 4];
    endfunction

    logic [X_W-1:0] w_expand;
    logic [X_W-1:0] w_mix;
    logic [R_W-1:0] w_sbox;
    logic [R_W-1:0] w_f;
    logic           r_valid;
    logic [R_W-1:0] r_f;

    // Expansion E: DES bit n lives at index 32-n.
    assign w_expand = {r_in[0],     r_in[31:27],
                       r_in[28:23], r_in[24:19],
                       r_in[20:15], r_in[16:11],
                       r_in[12:7],  r_in[8:3],
                       r_in[4:0],   r_in[31]};

    assign w_mix = w_expand ^ subkey;

    always_comb begin
        w_sbox = '0;
        for (int j = 0; j < N_SB; j++) begin
            w_sbox[31-4*j -: 4] = sbox_lookup(SBOX[j], w_mix[47-6*j -: 6]);
        end
    end

    // Permutation P
    assign w_f = {w_sbox[16], w_sbox[25], w_sbox[12], w_sbox[11],
                  w_sbox[3],  w_sbox[20], w_sbox[4],  w_sbox[15],
                  w_sbox[31], w_sbox[17], w_sbox[9],  w_sbox[6],
                  w_sbox[27], w_sbox[14], w_sbox[1],  w_sbox[22],
                  w_sbox[30], w_sbox[24], w_sbox[8],  w_sbox[18],
                  w_sbox[0],  w_sbox[5],  w_sbox[29], w_sbox[23],
                  w_sbox[13], w_sbox[19], w_sbox[2],  w_sbox[26],
                  w_sbox[10], w_sbox[21], w_sbox[28], w_sbox[7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_f     <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_f <= w_f;
            end
        end
    end

    assign out_valid = r_valid;
    assign f_out     = r_f;

endmodule

// File: tb/tb_des_f_function.sv
// Bench for des_f_function: directed FIPS vectors plus random R/K against a table-driven DES f model.
module tb_des_f_function;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] r_in;
    logic [47:0] subkey;
    logic        out_valid;
    logic [31:0] f_out;

    int n_vec = 0;
    int n_err = 0;

    des_f_function dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .r_in      (r_in),
        .subkey    (subkey),
        .out_valid (out_valid),
        .f_out     (f_out)
    );

    always #5 clk = ~clk;

    int E_TAB [48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
                       16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};
    int P_TAB [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                        2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    // Reference f(R,K) using 1-based DES bit positions straight from the tables.
    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] f;
        int b, row, col, val;
        for (int i = 1; i <= 48; i++) x[48-i] = r[32-E_TAB[i-1]] ^ k[48-i];
        for (int j = 0; j < 8; j++) begin
            b = 0;
            for (int t = 0; t < 6; t++) b = b * 2 + int'(x[47-6*j-t]);
            row = (b / 32) * 2 + (b % 2);
            col = (b / 2) % 16;
            val = SB[j][row*16 + col];
            for (int t = 0; t < 4; t++) s[31-4*j-t] = val[3-t];
        end
        for (int i = 1; i <= 32; i++) f[32-i] = s[32-P_TAB[i-1]];
        return f;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, then sample just after the next rising edge.
    task automatic drive(input bit rs, input bit v, input logic [31:0] r, input logic [47:0] k);
        @(negedge clk);
        rst      = rs;
        in_valid = v;
        r_in     = r;
        subkey   = k;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] R3 = 32'hF0AAF0AA;
    localparam logic [47:0] K3 = 48'h1B02EFFC7072;

    logic        exp_v;
    logic [31:0] exp_f;
    bit          rs_r, v_r;
    logic [31:0] r_r;
    logic [47:0] k_r;

    initial begin
        rst = 1'b1; in_valid = 1'b0; r_in = '0; subkey = '0;

        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, '0, '0);
            check_eq("rst_valid", 32'(out_valid), 32'h0);
            check_eq("rst_f", f_out, 32'h0);
        end
        drive(1'b0, 1'b0, 32'h12345678, 48'hABCDEF012345);
        check_eq("idle_valid", 32'(out_valid), 32'h0);
        check_eq("idle_f", f_out, 32'h0);

        drive(1'b0, 1'b1, '0, '0);
        check_eq("zero_valid", 32'(out_valid), 32'h1);
        check_eq("zero_f", f_out, 32'hD8D8DBBC);
        drive(1'b0, 1'b0, R3, K3);
        check_eq("hold_valid", 32'(out_valid), 32'h0);
        check_eq("hold_f", f_out, 32'hD8D8DBBC);

        drive(1'b0, 1'b1, '0, '0);
        check_eq("b2b0_valid", 32'(out_valid), 32'h1);
        check_eq("b2b0_f", f_out, 32'hD8D8DBBC);
        drive(1'b0, 1'b1, R3, K3);
        check_eq("b2b1_valid", 32'(out_valid), 32'h1);
        check_eq("b2b1_f", f_out, 32'h234AA9BB);
        drive(1'b0, 1'b0, 32'hDEADBEEF, 48'h0F0F0F0F0F0F);
        check_eq("b2b_idle_valid", 32'(out_valid), 32'h0);
        check_eq("b2b_idle_f", f_out, 32'h234AA9BB);

        drive(1'b1, 1'b1, R3, K3);
        check_eq("rst_in_valid", 32'(out_valid), 32'h0);
        check_eq("rst_in_f", f_out, 32'h0);

        exp_v = 1'b0;
        exp_f = '0;
        for (int n = 0; n < 10000; n++) begin
            rs_r = ($urandom_range(0, 99) == 0);
            v_r  = ($urandom_range(0, 3) != 0);
            r_r  = $urandom;
            k_r  = {16'($urandom), $urandom};
            drive(rs_r, v_r, r_r, k_r);
            if (rs_r) begin
                exp_v = 1'b0;
                exp_f = '0;
            end else begin
                exp_v = v_r;
                if (v_r) exp_f = des_f(r_r, k_r);
            end
            check_eq("rand_valid", 32'(out_valid), 32'(exp_v));
            check_eq("rand_f", f_out, exp_f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
